// File: rtl/oc_rotate_pkg.sv
// Shared constants, state codes and command bundle
// for the operand-collector rotate controller.
package oc_rotate_pkg;

   localparam int NUM_WARP_LOG     = 2;
   localparam int SIZE_REGFILE_BR  = 5;
   localparam int REGFILE_BR_INDEX = NUM_WARP_LOG + SIZE_REGFILE_BR;
   localparam int SIZE_DATA        = 32;
   localparam int DRAIN_CYCLES     = 4;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DRAIN   = 3'd1;
   localparam logic [2:0] ST_SAVE    = 3'd2;
   localparam logic [2:0] ST_RESTORE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic ROT_OP_SAVE    = 1'b0;
   localparam logic ROT_OP_RESTORE = 1'b1;

   typedef struct packed {
      logic                    op;
      logic [NUM_WARP_LOG-1:0] warp;
   } rotCmd_t;

endpackage

// File: rtl/oc_rotate_skid.sv
// Single-entry registered output stage for the save stream.
// A new load always wins over draining the held word.
module oc_rotate_skid
   import oc_rotate_pkg::*;
#(
   parameter int Width = SIZE_DATA
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             ready,
   input  logic [Width-1:0] loadData,
   input  logic             loadLast,
   output logic             valid,
   output logic [Width-1:0] data,
   output logic             last
);

   // hold the word until it handshakes or is replaced
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= loadData;
         last  <= loadLast;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/oc_rotate_ctrl.sv
// Spills or fills one warp's register context through
// the operand-collector bank rotate port.
module oc_rotate_ctrl
   import oc_rotate_pkg::*;
#(
   parameter int DrainCycles = DRAIN_CYCLES
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic                        cmd_op_i,
   input  logic [NUM_WARP_LOG-1:0]     cmd_warp_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        error_o,
   output logic                        stall_o,
   output logic                        rotate_o,
   output logic                        rotateValid_o,
   output logic                        rotateWE_o,
   output logic [REGFILE_BR_INDEX-1:0] rotateRegAddr_o,
   output logic [SIZE_DATA-1:0]        rotateDin_o,
   input  logic [SIZE_DATA-1:0]        rotateDout_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [SIZE_DATA-1:0]        out_data_o,
   output logic                        out_last_o,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [SIZE_DATA-1:0]        in_data_i,
   input  logic                        in_last_i
);

   logic [2:0]                 state;
   rotCmd_t                    cmdQ;
   logic [SIZE_REGFILE_BR-1:0] idx;
   logic [3:0]                 drainCnt;
   logic                       exhausted;
   logic                       errQ;

   logic isIdle, isDrain, isSave, isRestore, isDone;
   logic accept, lastIdx, load, wrEn, saveEnd;

   assign isIdle    = (state == ST_IDLE);
   assign isDrain   = (state == ST_DRAIN);
   assign isSave    = (state == ST_SAVE);
   assign isRestore = (state == ST_RESTORE);
   assign isDone    = (state == ST_DONE);

   assign accept  = cmd_valid_i && isIdle;
   assign lastIdx = (idx == '1);
   assign load    = isSave && !exhausted
                 && (!out_valid_o || out_ready_i);
   assign wrEn    = isRestore && in_valid_i;
   assign saveEnd = isSave && exhausted && out_valid_o
                 && out_ready_i && out_last_o;

   assign cmd_ready_o     = isIdle;
   assign busy_o          = !isIdle;
   assign done_o          = isDone;
   assign error_o         = errQ;
   assign stall_o         = !isIdle;
   assign rotate_o        = (isSave && !exhausted) || isRestore;
   assign rotateValid_o   = rotate_o;
   assign rotateWE_o      = wrEn;
   assign rotateRegAddr_o = {cmdQ.warp, idx};
   assign rotateDin_o     = wrEn ? in_data_i : '0;
   assign in_ready_o      = isRestore;

   oc_rotate_skid #(
      .Width(SIZE_DATA)
   ) uSkid (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .ready    (isSave && out_ready_i),
      .loadData (rotateDout_i),
      .loadLast (lastIdx),
      .valid    (out_valid_o),
      .data     (out_data_o),
      .last     (out_last_o)
   );

   // sequence IDLE -> DRAIN -> SAVE|RESTORE -> DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:
               if (accept) state <= ST_DRAIN;
            ST_DRAIN:
               if (drainCnt == 4'd1)
                  state <= (cmdQ.op == ROT_OP_RESTORE)
                         ? ST_RESTORE : ST_SAVE;
            ST_SAVE:
               if (saveEnd) state <= ST_DONE;
            ST_RESTORE:
               if (wrEn && lastIdx) state <= ST_DONE;
            ST_DONE:
               state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   // latch the command, count the drain, walk the index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmdQ      <= '0;
         idx       <= '0;
         drainCnt  <= '0;
         exhausted <= 1'b0;
      end else if (accept) begin
         cmdQ.op   <= cmd_op_i;
         cmdQ.warp <= cmd_warp_i;
         idx       <= '0;
         drainCnt  <= 4'(DrainCycles);
         exhausted <= 1'b0;
      end else begin
         if (isDrain) drainCnt <= drainCnt - 4'd1;
         if (load || wrEn) idx <= idx + 1'b1;
         if (load && lastIdx) exhausted <= 1'b1;
      end
   end

   // sticky framing error: last marker must sit on index 31
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         errQ <= 1'b0;
      end else if (accept) begin
         errQ <= 1'b0;
      end else if (wrEn && (in_last_i != lastIdx)) begin
         errQ <= 1'b1;
      end
   end

endmodule

// File: tb/tb_oc_rotate_ctrl.sv
// Randomized self-checking bench for oc_rotate_ctrl
// against a word-level model of the warp register bank.
module tb_oc_rotate_ctrl;
   import oc_rotate_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic                        cmd_valid_i = 0;
   logic                        cmd_ready_o;
   logic                        cmd_op_i = 0;
   logic [NUM_WARP_LOG-1:0]     cmd_warp_i = '0;
   logic                        busy_o, done_o, error_o, stall_o;
   logic                        rotate_o, rotateValid_o, rotateWE_o;
   logic [REGFILE_BR_INDEX-1:0] rotateRegAddr_o;
   logic [SIZE_DATA-1:0]        rotateDin_o;
   logic [SIZE_DATA-1:0]        rotateDout_i;
   logic                        out_valid_o;
   logic                        out_ready_i = 0;
   logic [SIZE_DATA-1:0]        out_data_o;
   logic                        out_last_o;
   logic                        in_valid_i = 0;
   logic                        in_ready_o;
   logic [SIZE_DATA-1:0]        in_data_i = '0;
   logic                        in_last_i = 0;

   oc_rotate_ctrl dut (
      .clk(clk), .reset(reset),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_warp_i(cmd_warp_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
      .stall_o(stall_o), .rotate_o(rotate_o),
      .rotateValid_o(rotateValid_o), .rotateWE_o(rotateWE_o),
      .rotateRegAddr_o(rotateRegAddr_o),
      .rotateDin_o(rotateDin_o), .rotateDout_i(rotateDout_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_last_o(out_last_o),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_data_i(in_data_i), .in_last_i(in_last_i)
   );

   // physical bank driven by the DUT, preloaded addr=data
   logic [31:0] bank [128];
   logic        doInit = 1'b1;
   always @(posedge clk) begin
      if (doInit) begin
         for (int i = 0; i < 128; i++) bank[i] <= 32'(i);
      end else if (rotateValid_o && rotateWE_o) begin
         bank[rotateRegAddr_o] <= rotateDin_o;
      end
   end
   assign rotateDout_i = bank[rotateRegAddr_o];

   // reference contents the bench expects the bank to hold
   logic [31:0] refBank [128];

   int nChecks = 0;
   int nErrors = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic runSave(input int w, input int mode,
                          input bit timing);
      logic [31:0] expQ [$];
      logic [31:0] e, heldD;
      logic        heldV, rdy;
      int cyc, rotFirst, rotLast, stallFirst, lastHs, doneCyc;
      for (int k = 0; k < 32; k++) expQ.push_back(refBank[w*32+k]);
      rotFirst = -1; rotLast = -1; stallFirst = -1;
      lastHs = -1; doneCyc = -1; heldV = 0; heldD = '0;
      chk("save_cmd_rdy", cmd_ready_o, 1);
      chk("save_stall0", stall_o, 0);
      cmd_valid_i = 1; cmd_op_i = ROT_OP_SAVE;
      cmd_warp_i = NUM_WARP_LOG'(w);
      step();
      cmd_valid_i = 0;
      cyc = 1;
      chk("save_err_clr", error_o, 0);
      while (doneCyc < 0 && cyc < 400) begin
         if (stall_o && stallFirst < 0) stallFirst = cyc;
         if (rotate_o) begin
            if (rotFirst < 0) rotFirst = cyc;
            rotLast = cyc;
            chk("save_we0", rotateWE_o, 0);
         end
         if (done_o) doneCyc = cyc;
         if (heldV) begin
            chk("save_hold_v", out_valid_o, 1);
            chk("save_hold_d", out_data_o, heldD);
         end
         case (mode)
            0: rdy = 1'b1;
            1: rdy = ((cyc % 3) == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready_i = rdy;
         if (out_valid_o && rdy) begin
            if (expQ.size() == 0) begin
               chk("save_extra", 1, 0);
            end else begin
               e = expQ.pop_front();
               chk("save_data", out_data_o, e);
               chk("save_last", out_last_o, expQ.size() == 0);
               if (expQ.size() == 0) lastHs = cyc;
            end
         end
         heldV = out_valid_o && !rdy;
         heldD = out_data_o;
         step();
         cyc++;
      end
      out_ready_i = 0;
      chk("save_done_seen", doneCyc >= 0, 1);
      chk("save_left", expQ.size(), 0);
      chk("save_done_lat", doneCyc, lastHs + 1);
      chk("save_stall_drop", stall_o, 0);
      chk("save_idle_rdy", cmd_ready_o, 1);
      if (timing) begin
         chk("save_stall_first", stallFirst, 1);
         chk("save_rot_first", rotFirst, 5);
         chk("save_rot_last", rotLast, 36);
         chk("save_done_cyc", doneCyc, 38);
      end
   endtask

   task automatic runRestore(input int w, input int lastPos,
                             input int mode, input logic [31:0] base);
      int k, cyc;
      bit doneSeen;
      logic v;
      logic [31:0] d;
      k = 0; cyc = 0; doneSeen = 0;
      cmd_valid_i = 1; cmd_op_i = ROT_OP_RESTORE;
      cmd_warp_i = NUM_WARP_LOG'(w);
      step();
      cmd_valid_i = 0;
      chk("rst_err_clr", error_o, 0);
      while (!doneSeen && cyc < 400) begin
         if (done_o) begin
            doneSeen = 1;
         end else begin
            v = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            d = base + 32'(k);
            in_valid_i = v;
            in_data_i = d;
            in_last_i = (k == lastPos);
            #1;
            if (in_ready_o && v) begin
               chk("rst_we", rotateWE_o, 1);
               chk("rst_addr", rotateRegAddr_o, w*32 + k);
               chk("rst_din", rotateDin_o, d);
               if (k < 32) refBank[w*32+k] = d;
               k++;
            end else begin
               chk("rst_we0", rotateWE_o, 0);
            end
            step();
            cyc++;
         end
      end
      in_valid_i = 0; in_last_i = 0;
      chk("rst_done_seen", doneSeen, 1);
      chk("rst_writes", k, 32);
      chk("rst_error", error_o, lastPos != 31);
      step();
      chk("rst_err_sticky", error_o, lastPos != 31);
   endtask

   initial begin
      int c, acc, acc1, acc2, done1, nDone, w, lp;
      bit hit;
      for (int i = 0; i < 128; i++) refBank[i] = 32'(i);
      repeat (3) @(negedge clk);
      chk("reset_outs",
          {cmd_ready_o, busy_o, done_o, error_o, stall_o,
           rotate_o, rotateValid_o, rotateWE_o,
           out_valid_o, out_last_o, in_ready_o},
          11'b10000000000);
      chk("reset_addr", rotateRegAddr_o, 0);
      chk("reset_data", out_data_o, 0);
      doInit = 0;
      reset = 1;
      step();

      runSave(2, 0, 1);
      runSave(1, 1, 0);
      runRestore(3, 31, 0, 32'hA000_0000);
      runSave(3, 0, 0);
      runRestore(0, 9, 0, 32'hB000_0000);
      runSave(0, 2, 0);

      cmd_valid_i = 1; cmd_op_i = ROT_OP_SAVE; cmd_warp_i = 0;
      out_ready_i = 1;
      step();
      cmd_valid_i = 0;
      hit = 0; c = 0;
      while (!hit && c < 200) begin
         if (rotate_o && rotateRegAddr_o[4:0] == 5'd12) hit = 1;
         else begin step(); c++; end
      end
      chk("rst12_reached", hit, 1);
      #2 reset = 0;
      #1;
      chk("rst12_outs",
          {cmd_ready_o, busy_o, done_o, error_o, stall_o,
           rotate_o, rotateValid_o, rotateWE_o,
           out_valid_o, out_last_o, in_ready_o},
          11'b10000000000);
      chk("rst12_addr", rotateRegAddr_o, 0);
      chk("rst12_data", out_data_o, 0);
      out_ready_i = 0;
      @(negedge clk);
      reset = 1;
      step();
      runSave(0, 0, 0);

      cmd_valid_i = 1; cmd_op_i = ROT_OP_SAVE; cmd_warp_i = 1;
      out_ready_i = 1;
      acc = 0; acc1 = -1; acc2 = -1; done1 = -1; nDone = 0; c = 0;
      while (nDone < 2 && c < 300) begin
         if (cmd_valid_i && cmd_ready_o) begin
            acc++;
            if (acc == 1) acc1 = c; else acc2 = c;
         end
         if (done_o) begin
            nDone++;
            if (done1 < 0) done1 = c;
         end
         step();
         c++;
         if (acc >= 2) cmd_valid_i = 0;
      end
      cmd_valid_i = 0; out_ready_i = 0;
      chk("hold_accepts", acc, 2);
      chk("hold_first", acc1, 0);
      chk("hold_second", acc2, done1 + 1);
      chk("hold_dones", nDone, 2);
      step();

      for (int n = 0; n < 6; n++) begin
         w = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            runSave(w, 2, 0);
         end else begin
            lp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : 31;
            runRestore(w, lp, 1, $urandom);
         end
      end
      runSave(3, 2, 0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
